// File: rtl/priority_5encoder_pkg.sv
// Shared control definitions for the 32-to-5 priority encoder: vector and
// code widths (matching the 5-bit ctrl_opcode index) and the FSM state type.
package priority_5encoder_pkg;

   localparam int ENC_N = 32;
   localparam int ENC_W = 5;

   // W-bit opcode index, same width as ctrl_opcode
   typedef logic [ENC_W-1:0] code_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

endpackage

// File: rtl/priority_5encoder_lsb.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit of vec_i
// plus a flag telling whether any bit is set at all.
module lsb_5encoder #(
   parameter int N = 32,
   parameter int W = 5
) (
   input  logic [N-1:0] vec_i,
   output logic [W-1:0] idx_o,
   output logic         any_o
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = W'(i);
         end
      end
   end

   assign any_o = |vec_i;

endmodule

// File: rtl/priority_5encoder.sv
// Sequential 32-to-5 priority encoder. Accepts a request vector in IDLE, then
// emits the index of every set bit, one code per out handshake, in priority
// order. out_last marks the final code of the vector.
module priority_5encoder
   import priority_5encoder_pkg::*;
#(
   parameter int N         = ENC_N,
   parameter int W         = ENC_W,
   parameter int MSB_FIRST = 0
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_code,
   output logic         out_last
);

   localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] MAX_IDX = W'(N - 1);

   state_t         state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic [W-1:0]   code_q, code_d;
   logic           last_q, last_d;
   logic           valid_q, valid_d;

   logic [N-1:0]   pend_clr;
   logic [N-1:0]   enc_src;
   logic [N-1:0]   enc_vec;
   logic [W-1:0]   lsb_idx;
   logic [W-1:0]   prio_idx;
   logic           enc_any;
   logic           src_single;

   // Pending set with the code currently on the output removed
   assign pend_clr = pending_q & ~(ONE << code_q);

   // In IDLE the next code comes from the incoming vector, in EMIT from what
   // remains after the current code is consumed
   assign enc_src = (state_q == ST_IDLE) ? in_vec : pend_clr;

   // MSB-first priority reuses the LSB encoder on the bit-reversed vector
   for (genvar g = 0; g < N; g++) begin : g_order
      assign enc_vec[g] = (MSB_FIRST != 0) ? enc_src[N-1-g] : enc_src[g];
   end

   lsb_5encoder #(
      .N (N),
      .W (W)
   ) u_lsb (
      .vec_i (enc_vec),
      .idx_o (lsb_idx),
      .any_o (enc_any)
   );

   assign prio_idx   = (MSB_FIRST != 0) ? (MAX_IDX - lsb_idx) : lsb_idx;
   // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing
   assign src_single = enc_any && ((enc_src & (enc_src - ONE)) == '0);

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = valid_q;
   assign out_code  = code_q;
   assign out_last  = last_q;

   // Next-state and datapath load decisions for the IDLE/EMIT machine
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      code_d    = code_q;
      last_d    = last_q;
      valid_d   = valid_q;
      case (state_q)
         ST_IDLE: begin
            // A zero vector is consumed silently and leaves us in IDLE
            if (in_valid && enc_any) begin
               pending_d = in_vec;
               code_d    = prio_idx;
               last_d    = src_single;
               valid_d   = 1'b1;
               state_d   = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (valid_q && out_ready) begin
               if (last_q) begin
                  pending_d = '0;
                  valid_d   = 1'b0;
                  state_d   = ST_IDLE;
               end else begin
                  pending_d = pend_clr;
                  code_d    = prio_idx;
                  last_d    = src_single;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any vector in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         code_q    <= '0;
         last_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         code_q    <= code_d;
         last_q    <= last_d;
         valid_q   <= valid_d;
      end
   end

endmodule

// File: tb/tb_priority_5encoder.sv
// Bench for priority_5encoder: an LSB-first and an MSB-first instance share
// the same inputs and are checked against a bit-scanning reference model.
module tb_priority_5encoder;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_vec = '0;
   logic        out_ready = 1'b0;

   logic        rdy0, val0, last0;
   logic [4:0]  code0;
   logic        rdy1, val1, last1;
   logic [4:0]  code1;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   priority_5encoder #(.N(32), .W(5), .MSB_FIRST(0)) dut_lsb (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (rdy0),
      .in_vec    (in_vec),
      .out_valid (val0),
      .out_ready (out_ready),
      .out_code  (code0),
      .out_last  (last0)
   );

   priority_5encoder #(.N(32), .W(5), .MSB_FIRST(1)) dut_msb (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (rdy1),
      .in_vec    (in_vec),
      .out_valid (val1),
      .out_ready (out_ready),
      .out_code  (code1),
      .out_last  (last1)
   );

   // Reference: k-th set bit of v in priority order, -1 if none
   function automatic int nth_code(input logic [31:0] v, input int k, input bit msb);
      int seen;
      seen = 0;
      for (int i = 0; i < 32; i++) begin
         int b;
         b = msb ? 31 - i : i;
         if (v[b]) begin
            if (seen == k) return b;
            seen++;
         end
      end
      return -1;
   endfunction

   function automatic int popcnt(input logic [31:0] v);
      int c;
      c = 0;
      for (int i = 0; i < 32; i++) c += int'(v[i]);
      return c;
   endfunction

   // Present one vector for one cycle; returns on the negedge after acceptance
   task automatic send(input logic [31:0] v);
      @(negedge clock);
      in_valid = 1'b1;
      in_vec   = v;
      @(negedge clock);
      in_valid = 1'b0;
      in_vec   = '0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #12;
      checks++;
      if (val0 !== 1'b0 || rdy0 !== 1'b1 || code0 !== 5'd0 || last0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_lsb: valid=%b ready=%b code=%0d last=%b, need 0 1 0 0", val0, rdy0, code0, last0);
      end
      checks++;
      if (val1 !== 1'b0 || rdy1 !== 1'b1 || code1 !== 5'd0 || last1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_msb: valid=%b ready=%b code=%0d last=%b, need 0 1 0 0", val1, rdy1, code1, last1);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_sparse;
      logic [31:0] v;
      int n;
      v = 32'h8000_0011;
      n = popcnt(v);
      out_ready = 1'b1;
      send(v);
      for (int k = 0; k < n; k++) begin
         checks++;
         if (val0 !== 1'b1 || int'(code0) != nth_code(v, k, 0) || last0 !== (k == n - 1)) begin
            errors++;
            $display("FAIL sparse_lsb[%0d]: valid=%b code=%0d last=%b, need 1 %0d %b", k, val0, code0, last0, nth_code(v, k, 0), k == n - 1);
         end
         checks++;
         if (val1 !== 1'b1 || int'(code1) != nth_code(v, k, 1) || last1 !== (k == n - 1)) begin
            errors++;
            $display("FAIL sparse_msb[%0d]: valid=%b code=%0d last=%b, need 1 %0d %b", k, val1, code1, last1, nth_code(v, k, 1), k == n - 1);
         end
         @(negedge clock);
      end
      checks++;
      if (val0 !== 1'b0 || rdy0 !== 1'b1 || val1 !== 1'b0 || rdy1 !== 1'b1) begin
         errors++;
         $display("FAIL sparse_end: valid=%b/%b ready=%b/%b, need 0/0 1/1", val0, val1, rdy0, rdy1);
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] v;
      logic [4:0]  pat;
      int k;
      v   = 32'h0000_00A0;
      pat = 5'b10100;   // out_ready per cycle, first cycle in bit 0
      k   = 0;
      out_ready = 1'b0;
      send(v);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (val0 !== 1'b1 || int'(code0) != nth_code(v, k, 0) || last0 !== (k == 1)) begin
            errors++;
            $display("FAIL bp_lsb[%0d]: valid=%b code=%0d last=%b, need 1 %0d %b", c, val0, code0, last0, nth_code(v, k, 0), k == 1);
         end
         checks++;
         if (val1 !== 1'b1 || int'(code1) != nth_code(v, k, 1) || last1 !== (k == 1)) begin
            errors++;
            $display("FAIL bp_msb[%0d]: valid=%b code=%0d last=%b, need 1 %0d %b", c, val1, code1, last1, nth_code(v, k, 1), k == 1);
         end
         out_ready = pat[c];
         if (pat[c]) k++;
         @(negedge clock);
      end
      checks++;
      if (val0 !== 1'b0 || rdy0 !== 1'b1 || val1 !== 1'b0) begin
         errors++;
         $display("FAIL bp_end: valid=%b/%b ready=%b, need 0/0 1", val0, val1, rdy0);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_zero;
      send(32'h0);
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (val0 !== 1'b0 || rdy0 !== 1'b1 || val1 !== 1'b0 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL zero[%0d]: valid=%b/%b ready=%b/%b, need 0/0 1/1", c, val0, val1, rdy0, rdy1);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_full;
      int lasts0, lasts1;
      lasts0 = 0;
      lasts1 = 0;
      out_ready = 1'b1;
      send(32'hFFFF_FFFF);
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (val0 !== 1'b1 || int'(code0) != k || rdy0 !== 1'b0) begin
            errors++;
            $display("FAIL full_lsb[%0d]: valid=%b code=%0d ready=%b, need 1 %0d 0", k, val0, code0, rdy0, k);
         end
         checks++;
         if (val1 !== 1'b1 || int'(code1) != 31 - k) begin
            errors++;
            $display("FAIL full_msb[%0d]: valid=%b code=%0d, need 1 %0d", k, val1, code1, 31 - k);
         end
         if (last0 === 1'b1) lasts0++;
         if (last1 === 1'b1) lasts1++;
         @(negedge clock);
      end
      checks++;
      if (lasts0 != 1 || lasts1 != 1 || val0 !== 1'b0) begin
         errors++;
         $display("FAIL full_last: last count %0d/%0d valid=%b, need 1/1 0", lasts0, lasts1, val0);
      end
   endtask

   task automatic test_reset_midstream;
      out_ready = 1'b1;
      send(32'hFFFF_FFFF);
      repeat (3) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (val0 !== 1'b0 || rdy0 !== 1'b1 || val1 !== 1'b0 || rdy1 !== 1'b1) begin
         errors++;
         $display("FAIL midreset: valid=%b/%b ready=%b/%b, need 0/0 1/1", val0, val1, rdy0, rdy1);
      end
      @(negedge clock);
      reset = 1'b0;
      send(32'h0000_0001);
      checks++;
      if (val0 !== 1'b1 || code0 !== 5'd0 || last0 !== 1'b1 || val1 !== 1'b1 || code1 !== 5'd0 || last1 !== 1'b1) begin
         errors++;
         $display("FAIL after_reset: lsb %b %0d %b msb %b %0d %b, need 1 0 1", val0, code0, last0, val1, code1, last1);
      end
      @(negedge clock);
      checks++;
      if (val0 !== 1'b0 || rdy0 !== 1'b1) begin
         errors++;
         $display("FAIL after_reset_end: valid=%b ready=%b, need 0 1", val0, rdy0);
      end
   endtask

   task automatic test_random;
      for (int t = 0; t < 40; t++) begin
         logic [31:0] v, acc;
         int k, n, cyc;
         v = $urandom;
         if (t % 3 == 0) v = v & $urandom & $urandom;
         if (t == 7) v = '0;
         n   = popcnt(v);
         acc = '0;
         k   = 0;
         cyc = 0;
         out_ready = 1'b1;
         send(v);
         while (val0 === 1'b1 && cyc < 200) begin
            checks++;
            if (int'(code0) != nth_code(v, k, 0) || last0 !== (k == n - 1)) begin
               errors++;
               $display("FAIL rnd_lsb v=%h k=%0d: code=%0d last=%b, need %0d %b", v, k, code0, last0, nth_code(v, k, 0), k == n - 1);
            end
            checks++;
            if (val1 !== 1'b1 || int'(code1) != nth_code(v, k, 1) || last1 !== (k == n - 1)) begin
               errors++;
               $display("FAIL rnd_msb v=%h k=%0d: valid=%b code=%0d last=%b, need 1 %0d", v, k, val1, code1, last1, nth_code(v, k, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_ready) begin
               acc = acc | (32'h1 << code0);
               k++;
            end
            @(negedge clock);
            cyc++;
         end
         checks++;
         if (cyc >= 200 || acc !== v || k != n) begin
            errors++;
            $display("FAIL rnd_scoreboard v=%h: rebuilt=%h codes=%0d cycles=%0d, need %h %0d", v, acc, k, cyc, v, n);
         end
      end
   endtask

   initial begin
      test_reset;
      test_sparse;
      test_backpressure;
      test_zero;
      test_full;
      test_reset_midstream;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
